branch_target_buffer: RTL
=========================

Name: branch_target_buffer

Overview:
- Parametrised next-generation branch predictor for the fetch stage.
- Replaces the direct-mapped predict cache with a 2-way set-associative table. Each entry holds a tag, a target and a 2-bit saturating counter.
- Adds per-set LRU replacement, allocate-on-taken, and a sequential invalidate sweep.
- Looked up combinationally by the fetch PC; updated from execute with resolved branch outcomes.

Parameters:
- ADDR_W, 32, instruction address and target width.
- SETS, 16, number of sets; power of two, at least 2; IDX_W = log2(SETS).
- TAG_W, ADDR_W-IDX_W-2, derived, not overridable.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous active-low reset.
- RAddr  in  ADDR_W  fetch PC to look up.
- Hit  out  1  valid tag match in the indexed set.
- Predict  out  ADDR_W  target of the hit way; 0 on miss.
- CB  out  2  counter of the hit way; 2'b00 on miss.
- PCSource  out  1  Hit & CB[1] (redirect fetch to Predict).
- WE  in  1  update strobe from execute, one per resolved branch.
- WAddr  in  ADDR_W  address of the resolved branch instruction.
- Taken  in  1  resolved outcome.
- Data  in  ADDR_W  resolved target.
- Inval  in  1  single-cycle request to clear the whole table.
- Busy  out  1  invalidate sweep in progress.

Behaviour:
- Address split: index = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2]. Bits [1:0] are ignored.
- Reset (Rst=0, asynchronous):
  - All valid bits = 0, LRU bits = 0, FSM = IDLE, Busy = 0.
  - Tag, target and counter storage is not reset.
  - Outputs read miss in the same cycle reset asserts.
- Lookup is combinational, zero latency:
  - Hit when exactly one way is valid with a matching tag.
  - Both ways matching is illegal; treat it as way0 and flag it with an assertion.
  - While Busy=1, Hit=0 regardless of contents.
- Update is registered, effective at the next rising edge.
  - On WE & !Busy & hit in way w:
    - counter = sat(counter+1) if Taken, sat(counter-1) if not. Saturates at 3 and at 0.
    - If Taken, target = Data.
    - LRU[set] = !w, i.e. the other way becomes the victim.
  - On WE & !Busy & miss & Taken, allocate:
    - Victim is the first invalid way (way0 before way1); if both are valid, way LRU[set].
    - Write tag, target = Data, counter = 2'b10, valid = 1, LRU[set] = !victim.
  - On WE & !Busy & miss & !Taken: no change.
- Lookup and update in the same cycle, same set: the lookup returns pre-update contents. There is no bypass.
- Invalidate FSM, states IDLE and SWEEP, counter ptr of width IDX_W:
  - IDLE, Inval=1: go to SWEEP, ptr = 0, Busy = 1 from the next cycle.
  - SWEEP: each cycle clear both valid bits and the LRU bit of set ptr, then ptr = ptr+1.
  - When ptr == SETS-1, clear that set and return to IDLE. Busy drops the cycle after.
  - Sweep lasts exactly SETS cycles.
  - Inval while Busy is ignored; the sweep does not restart.
  - WE while Busy is dropped (no write, no counter change).
  - WE and Inval in the same IDLE cycle: the update is performed, then the sweep starts. The sweep clears the new entry.
- Reset during SWEEP aborts to IDLE with all entries invalid.
- Busy is intended to be OR-ed into the hazard unit's PC stall by the integrator. The block itself never stalls.

Decomposition:
- Shared package btb_pkg: counter encodings (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11), counter reset/allocate value WT, FSM state enum (IDLE, SWEEP), and function sat2(ctr, up).
- One natural sub-module, btb_way: a single way's storage array (valid, tag, target, ctr) with combinational read port and synchronous write port. Instantiated twice.
- Set/LRU logic and the FSM stay in the top.

Test Plan:
- Reset, then RAddr=0x00000040 -> Hit=0, Predict=0, CB=00, PCSource=0, Busy=0.
- WE, WAddr=0x40, Taken=1, Data=0x100 -> next cycle, RAddr=0x40 gives Hit=1, Predict=0x100, CB=10, PCSource=1. WE with Taken=0 twice -> CB=01 then 00, PCSource=0. Two more not-taken keep CB=00.
- Taken-allocate 0x40, 0x440 and 0x840 (same set with SETS=16); touch 0x40 in between -> 0x440 is evicted, 0x40 and 0x840 hit, 0x440 misses.
- Same-cycle WE (allocate 0x80) and RAddr=0x80 -> Hit=0 that cycle, Hit=1 the next.
- Fill 4 sets, pulse Inval -> Busy high for exactly 16 cycles with Hit=0 throughout. A WE issued mid-sweep leaves no entry; all addresses miss afterwards.
- Assert Rst low at sweep cycle 5 -> Busy=0 immediately, all misses. A fresh Inval after release gives a full 16-cycle sweep.

Source files
------------

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared counter encodings, FSM states and helpers for the branch target buffer
package btb_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } btb_state_e;

    // Two-bit saturating step toward taken (up=1) or not-taken (up=0).
    function automatic logic [1:0] sat2(input logic [1:0] ctr, input logic up);
        if (up) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_way.sv
// rtl/btb_way.sv - one way of the BTB: valid/tag/target/counter array with two read ports and one write port
module btb_way #(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 26,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  r_idx,
    output logic              r_valid,
    output logic [TAG_W-1:0]  r_tag,
    output logic [ADDR_W-1:0] r_target,
    output logic [1:0]        r_ctr,
    input  logic [IDX_W-1:0]  u_idx,
    output logic              u_valid,
    output logic [TAG_W-1:0]  u_tag,
    output logic [ADDR_W-1:0] u_target,
    output logic [1:0]        u_ctr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [ADDR_W-1:0] wr_target,
    input  logic [1:0]        wr_ctr,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   valid_d;
    logic [TAG_W-1:0]  tag_mem    [SETS];
    logic [ADDR_W-1:0] target_mem [SETS];
    logic [1:0]        ctr_mem    [SETS];

    assign r_valid  = valid_q[r_idx];
    assign r_tag    = tag_mem[r_idx];
    assign r_target = target_mem[r_idx];
    assign r_ctr    = ctr_mem[r_idx];

    assign u_valid  = valid_q[u_idx];
    assign u_tag    = tag_mem[u_idx];
    assign u_target = target_mem[u_idx];
    assign u_ctr    = ctr_mem[u_idx];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
        if (clr_en) begin
            valid_d[clr_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
            ctr_mem[wr_idx]    <= wr_ctr;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - 2-way set-associative branch target buffer with LRU and invalidate sweep
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS   = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] RAddr,
    output logic              Hit,
    output logic [ADDR_W-1:0] Predict,
    output logic [1:0]        CB,
    output logic              PCSource,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WAddr,
    input  logic              Taken,
    input  logic [ADDR_W-1:0] Data,
    input  logic              Inval,
    output logic              Busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [IDX_W-1:0]  r_idx, u_idx, ptr_q, ptr_d;
    logic [TAG_W-1:0]  r_tag_in, u_tag_in;
    logic              r_v0, r_v1, u_v0, u_v1;
    logic [TAG_W-1:0]  r_t0, r_t1, u_t0, u_t1;
    logic [ADDR_W-1:0] r_tg0, r_tg1, u_tg0, u_tg1;
    logic [1:0]        r_c0, r_c1, u_c0, u_c1;
    logic              r_m0, r_m1, u_m0, u_m1, u_hit, u_way;
    logic              wr_en, wr_way, clr_en, upd_en;
    logic [ADDR_W-1:0] wr_target;
    logic [1:0]        wr_ctr;
    logic [SETS-1:0]   lru_q, lru_d;
    btb_state_e        state_q, state_d;
    logic              unused_addr_bits;

    assign r_idx    = RAddr[IDX_W+1:2];
    assign r_tag_in = RAddr[ADDR_W-1:IDX_W+2];
    assign u_idx    = WAddr[IDX_W+1:2];
    assign u_tag_in = WAddr[ADDR_W-1:IDX_W+2];
    assign unused_addr_bits = ^{RAddr[1:0], WAddr[1:0]};

    btb_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) u_way0 (
        .clk(Clk), .rst_n(Rst),
        .r_idx(r_idx), .r_valid(r_v0), .r_tag(r_t0), .r_target(r_tg0), .r_ctr(r_c0),
        .u_idx(u_idx), .u_valid(u_v0), .u_tag(u_t0), .u_target(u_tg0), .u_ctr(u_c0),
        .wr_en(wr_en && !wr_way), .wr_idx(u_idx), .wr_tag(u_tag_in),
        .wr_target(wr_target), .wr_ctr(wr_ctr),
        .clr_en(clr_en), .clr_idx(ptr_q)
    );

    btb_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) u_way1 (
        .clk(Clk), .rst_n(Rst),
        .r_idx(r_idx), .r_valid(r_v1), .r_tag(r_t1), .r_target(r_tg1), .r_ctr(r_c1),
        .u_idx(u_idx), .u_valid(u_v1), .u_tag(u_t1), .u_target(u_tg1), .u_ctr(u_c1),
        .wr_en(wr_en && wr_way), .wr_idx(u_idx), .wr_tag(u_tag_in),
        .wr_target(wr_target), .wr_ctr(wr_ctr),
        .clr_en(clr_en), .clr_idx(ptr_q)
    );

    assign Busy = (state_q == SWEEP);

    // Fetch lookup: a double match resolves to way0.
    assign r_m0     = r_v0 && (r_t0 == r_tag_in);
    assign r_m1     = r_v1 && (r_t1 == r_tag_in);
    assign Hit      = (r_m0 || r_m1) && !Busy;
    assign Predict  = !Hit ? '0 : (r_m0 ? r_tg0 : r_tg1);
    assign CB       = !Hit ? CTR_SNT : (r_m0 ? r_c0 : r_c1);
    assign PCSource = Hit && CB[1];

    assign u_m0  = u_v0 && (u_t0 == u_tag_in);
    assign u_m1  = u_v1 && (u_t1 == u_tag_in);
    assign u_hit = u_m0 || u_m1;
    assign u_way = !u_m0;

    always_comb begin
        upd_en    = WE && !Busy;
        wr_en     = 1'b0;
        wr_way    = 1'b0;
        wr_target = Data;
        wr_ctr    = CTR_ALLOC;
        lru_d     = lru_q;
        if (upd_en && u_hit) begin
            wr_en     = 1'b1;
            wr_way    = u_way;
            wr_target = Taken ? Data : (u_way ? u_tg1 : u_tg0);
            wr_ctr    = sat2(u_way ? u_c1 : u_c0, Taken);
            lru_d[u_idx] = !u_way;
        end else if (upd_en && Taken) begin
            wr_en  = 1'b1;
            wr_way = !u_v0 ? 1'b0 : (!u_v1 ? 1'b1 : lru_q[u_idx]);
            lru_d[u_idx] = !wr_way;
        end
        if (clr_en) begin
            lru_d[ptr_q] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Inval) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                clr_en = 1'b1;
                ptr_d  = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lru_q   <= lru_d;
        end
    end

    always @(posedge Clk) begin
        if (Rst && !Busy) begin
            assert (!(r_m0 && r_m1));
            assert (!(u_m0 && u_m1));
        end
    end

endmodule
